// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: assembles a 32-bit little-endian word from a
// byte-wide instruction memory and hands it to execute with a valid/ready pair.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0000000000000000
) (
  input  logic        clkOut,
  input  logic        rstN,
  output logic [9:0]  raddr,
  input  logic [7:0]  rdata,
  input  logic        redirect,
  input  logic [63:0] redirectPc,
  input  logic        insReady,
  output logic        insValid,
  output logic [31:0] curIns,
  output logic [63:0] pc,
  output logic        isUndefined,
  output logic [15:0] insCount
);

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    VALID  = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state, stateNext;
  logic [63:0] pcNext;
  logic [31:0] curInsNext;
  logic        insValidNext;
  logic        isUndefinedNext;
  logic [15:0] insCountNext;
  logic [1:0]  byteIdx;
  logic        pcIllegal;

  // Only word-aligned addresses inside the 1 KiB instruction memory are legal.
  assign pcIllegal = (pc[1:0] != 2'b00) || (pc[63:10] != 54'd0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    byteIdx = 2'd0;
    case (state)
      FETCH1:  byteIdx = 2'd1;
      FETCH2:  byteIdx = 2'd2;
      FETCH3:  byteIdx = 2'd3;
      default: byteIdx = 2'd0;
    endcase
    raddr = pc[9:0] + {8'd0, byteIdx};
  end

  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    curInsNext      = curIns;
    insValidNext    = insValid;
    isUndefinedNext = isUndefined;
    insCountNext    = insCount;

    if (state != HALT && redirect) begin
      // Redirect wins, but a word held in VALID with insReady is still consumed.
      pcNext       = redirectPc;
      insValidNext = 1'b0;
      stateNext    = FETCH0;
      if (state == VALID && insReady) insCountNext = insCount + 16'd1;
    end else begin
      case (state)
        FETCH0: begin
          if (pcIllegal) begin
            stateNext       = HALT;
            isUndefinedNext = 1'b1;
          end else begin
            curInsNext[7:0] = rdata;
            stateNext       = FETCH1;
          end
        end
        FETCH1: begin
          curInsNext[15:8] = rdata;
          stateNext        = FETCH2;
        end
        FETCH2: begin
          curInsNext[23:16] = rdata;
          stateNext         = FETCH3;
        end
        FETCH3: begin
          curInsNext[31:24] = rdata;
          insValidNext      = 1'b1;
          stateNext         = VALID;
        end
        VALID: begin
          if (insReady) begin
            pcNext       = pc + 64'd4;
            insValidNext = 1'b0;
            insCountNext = insCount + 16'd1;
            stateNext    = FETCH0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkOut or negedge rstN) begin
    if (!rstN) begin
      state       <= FETCH0;
      pc          <= RESET_PC;
      curIns      <= 32'd0;
      insValid    <= 1'b0;
      isUndefined <= 1'b0;
      insCount    <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= stateNext;
      pc          <= pcNext;
      curIns      <= curInsNext;
      insValid    <= insValidNext;
      isUndefined <= isUndefinedNext;
      insCount    <= insCountNext;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// accept stream checked against a cycle-count model of the fetch protocol.
module tb_fetch_sequencer;

  logic        clkOut = 1'b0;
  logic        rstN = 1'b0;
  logic [9:0]  raddr;
  logic [7:0]  rdata;
  logic        redirect = 1'b0;
  logic [63:0] redirectPc = 64'd0;
  logic        insReady = 1'b0;
  logic        insValid;
  logic [31:0] curIns;
  logic [63:0] pc;
  logic        isUndefined;
  logic [15:0] insCount;

  logic [7:0] mem [0:1023];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clkOut = ~clkOut;
  assign rdata = mem[raddr];

  fetch_sequencer dut (
    .clkOut(clkOut), .rstN(rstN), .raddr(raddr), .rdata(rdata),
    .redirect(redirect), .redirectPc(redirectPc), .insReady(insReady),
    .insValid(insValid), .curIns(curIns), .pc(pc),
    .isUndefined(isUndefined), .insCount(insCount)
  );

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  task automatic step();
    @(negedge clkOut);
  endtask

  task automatic do_reset();
    rstN = 1'b0; redirect = 1'b0; insReady = 1'b0; redirectPc = 64'd0;
    step();
    rstN = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (insValid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #1;
    tests_run++; if (insValid !== 1'b0) begin tests_failed++; $display("FAIL reset_insValid got=%0b exp=0", insValid); end
    tests_run++; if (pc !== 64'd0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=0", pc); end
    tests_run++; if (curIns !== 32'd0) begin tests_failed++; $display("FAIL reset_curIns got=%h exp=0", curIns); end
    tests_run++; if (isUndefined !== 1'b0) begin tests_failed++; $display("FAIL reset_isUndefined got=%0b exp=0", isUndefined); end
    tests_run++; if (insCount !== 16'd0) begin tests_failed++; $display("FAIL reset_insCount got=%h exp=0", insCount); end
    tests_run++; if (raddr !== 10'd0) begin tests_failed++; $display("FAIL reset_raddr got=%h exp=0", raddr); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      step();
      tests_run++; if (insValid !== 1'b0) begin tests_failed++; $display("FAIL first_early_valid cycle=%0d got=%0b exp=0", c, insValid); end
    end
    step();
    tests_run++; if (insValid !== 1'b1) begin tests_failed++; $display("FAIL first_valid got=%0b exp=1", insValid); end
    tests_run++; if (curIns !== 32'h12345678) begin tests_failed++; $display("FAIL first_word got=%h exp=12345678", curIns); end
    tests_run++; if (pc !== 64'd0) begin tests_failed++; $display("FAIL first_pc got=%h exp=0", pc); end
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if ({insValid, curIns, pc} !== {1'b1, 32'h12345678, 64'd0}) begin
        tests_failed++;
        $display("FAIL hold_stable cycle=%0d got v=%0b w=%h pc=%h exp v=1 w=12345678 pc=0", c, insValid, curIns, pc);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    insReady = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      tests_run++;
      if (insValid !== (c == 4 || c == 9)) begin
        tests_failed++; $display("FAIL stream_valid cycle=%0d got=%0b exp=%0b", c, insValid, (c == 4 || c == 9));
      end
      if (c == 4) begin
        tests_run++; if (curIns !== word_at(64'd0)) begin tests_failed++; $display("FAIL stream_word0 got=%h exp=%h", curIns, word_at(64'd0)); end
      end
      if (c == 9) begin
        tests_run++; if (curIns !== word_at(64'd4)) begin tests_failed++; $display("FAIL stream_word1 got=%h exp=%h", curIns, word_at(64'd4)); end
      end
    end
    tests_run++; if (insCount !== 16'd2) begin tests_failed++; $display("FAIL stream_count got=%0d exp=2", insCount); end
    insReady = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [63:0] exp_pc;
    int phase;
    int exp_cnt;
    logic rdy;
    logic [9:0] exp_raddr;
    do_reset();
    exp_pc = 64'd0; phase = 0; exp_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      rdy = 1'($urandom_range(0, 1));
      insReady = rdy;
      step();
      // A word needs four fetch cycles, then is held until an accept.
      if (phase == 4) begin
        if (rdy) begin phase = 0; exp_pc = exp_pc + 64'd4; exp_cnt++; end
      end else begin
        phase++;
      end
      exp_raddr = exp_pc[9:0] + ((phase < 4) ? 10'(phase) : 10'd0);
      tests_run++;
      if (insValid !== (phase == 4) || pc !== exp_pc || insCount !== 16'(exp_cnt) || raddr !== exp_raddr ||
          (phase == 4 && curIns !== word_at(exp_pc))) begin
        tests_failed++;
        $display("FAIL random_stream cycle=%0d got v=%0b pc=%h cnt=%0d ra=%h w=%h exp v=%0b pc=%h cnt=%0d ra=%h w=%h",
                 c, insValid, pc, insCount, raddr, curIns, (phase == 4), exp_pc, exp_cnt, exp_raddr, word_at(exp_pc));
      end
    end
    insReady = 1'b0;
  endtask

  task automatic test_redirect_mid_fetch();
    do_reset();
    step(); step();
    redirect = 1'b1; redirectPc = 64'h100;
    step();
    redirect = 1'b0;
    tests_run++; if (raddr !== 10'h100) begin tests_failed++; $display("FAIL redir_raddr got=%h exp=100", raddr); end
    tests_run++; if (insValid !== 1'b0) begin tests_failed++; $display("FAIL redir_valid got=%0b exp=0", insValid); end
    tests_run++; if (pc !== 64'h100) begin tests_failed++; $display("FAIL redir_pc got=%h exp=100", pc); end
    for (int c = 1; c <= 3; c++) begin
      step();
      tests_run++; if (insValid !== 1'b0) begin tests_failed++; $display("FAIL redir_early_valid cycle=%0d got=%0b exp=0", c, insValid); end
    end
    step();
    tests_run++; if (insValid !== 1'b1) begin tests_failed++; $display("FAIL redir_late_valid got=%0b exp=1", insValid); end
    tests_run++; if (curIns !== word_at(64'h100)) begin tests_failed++; $display("FAIL redir_word got=%h exp=%h", curIns, word_at(64'h100)); end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    wait_valid(8);
    tests_run++; if (insValid !== 1'b1) begin tests_failed++; $display("FAIL racc_reach_valid got=%0b exp=1", insValid); end
    redirect = 1'b1; redirectPc = 64'h20; insReady = 1'b1;
    step();
    redirect = 1'b0; insReady = 1'b0;
    tests_run++; if (pc !== 64'h20) begin tests_failed++; $display("FAIL racc_pc got=%h exp=20", pc); end
    tests_run++; if (insCount !== 16'd1) begin tests_failed++; $display("FAIL racc_count got=%0d exp=1", insCount); end
    tests_run++; if (insValid !== 1'b0) begin tests_failed++; $display("FAIL racc_valid got=%0b exp=0", insValid); end
    tests_run++; if (raddr !== 10'h20) begin tests_failed++; $display("FAIL racc_raddr got=%h exp=20", raddr); end
    step(); step(); step(); step();
    tests_run++; if (insValid !== 1'b1 || curIns !== word_at(64'h20)) begin
      tests_failed++; $display("FAIL racc_word got v=%0b w=%h exp v=1 w=%h", insValid, curIns, word_at(64'h20));
    end
  endtask

  task automatic test_halt();
    logic [63:0] targets [3];
    targets[0] = 64'h402; targets[1] = 64'h400; targets[2] = 64'h8000_0000_0000_0000;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      step();
      redirect = 1'b1; redirectPc = targets[t];
      step();
      redirect = 1'b0;
      step();
      tests_run++;
      if (isUndefined !== 1'b1 || insValid !== 1'b0 || pc !== targets[t]) begin
        tests_failed++; $display("FAIL halt_enter target=%h got u=%0b v=%0b pc=%h exp u=1 v=0 pc=%h", targets[t], isUndefined, insValid, pc, targets[t]);
      end
      redirect = 1'b1; redirectPc = 64'd0; insReady = 1'b1;
      for (int c = 0; c < 5; c++) step();
      redirect = 1'b0; insReady = 1'b0;
      tests_run++;
      if (isUndefined !== 1'b1 || insValid !== 1'b0 || pc !== targets[t] || insCount !== 16'd0) begin
        tests_failed++; $display("FAIL halt_sticky target=%h got u=%0b v=%0b pc=%h cnt=%0d exp u=1 v=0 pc=%h cnt=0", targets[t], isUndefined, insValid, pc, insCount, targets[t]);
      end
      #1 rstN = 1'b0;
      #1;
      tests_run++; if (isUndefined !== 1'b0 || pc !== 64'd0) begin
        tests_failed++; $display("FAIL halt_reset got u=%0b pc=%h exp u=0 pc=0", isUndefined, pc);
      end
      step();
      rstN = 1'b1;
      step(); step(); step(); step();
      tests_run++; if (insValid !== 1'b1 || curIns !== word_at(64'd0)) begin
        tests_failed++; $display("FAIL halt_refetch got v=%0b w=%h exp v=1 w=%h", insValid, curIns, word_at(64'd0));
      end
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    wait_valid(8);
    force dut.insCount = 16'hFFFE;
    #1 release dut.insCount;
    tests_run++; if (insCount !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_preload got=%h exp=fffe", insCount); end
    insReady = 1'b1;
    step();
    insReady = 1'b0;
    tests_run++; if (insCount !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_ffff got=%h exp=ffff", insCount); end
    wait_valid(8);
    insReady = 1'b1;
    step();
    insReady = 1'b0;
    tests_run++; if (insCount !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero got=%h exp=0000", insCount); end
  endtask

  task automatic test_async_reset();
    do_reset();
    wait_valid(8);
    insReady = 1'b1;
    step();
    insReady = 1'b0;
    step();
    #2 rstN = 1'b0;
    #1;
    tests_run++;
    if (insCount !== 16'd0 || pc !== 64'd0 || insValid !== 1'b0 || curIns !== 32'd0 || isUndefined !== 1'b0 || raddr !== 10'd0) begin
      tests_failed++;
      $display("FAIL async_reset got cnt=%0d pc=%h v=%0b w=%h u=%0b ra=%h exp all zero", insCount, pc, insValid, curIns, isUndefined, raddr);
    end
    step();
    rstN = 1'b1;
    step(); step(); step(); step();
    tests_run++; if (insValid !== 1'b1 || pc !== 64'd0 || curIns !== word_at(64'd0)) begin
      tests_failed++; $display("FAIL async_refetch got v=%0b pc=%h w=%h exp v=1 pc=0 w=%h", insValid, pc, curIns, word_at(64'd0));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[32] = 8'hA1; mem[33] = 8'hA2; mem[34] = 8'hA3; mem[35] = 8'hA4;
    test_reset();
    test_first_fetch();
    test_stream();
    test_random_stream();
    test_redirect_mid_fetch();
    test_redirect_accept();
    test_halt();
    test_count_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule
